spike_rr_arbiter: RTL

Round-robin arbiter that sits in front of the `delay` unit. It collects single-cycle spike pulses from N_IN presynaptic inputs, which may be simultaneous, and issues them one per cycle as a one-hot spike. Each issued spike carries the number of cycles it waited, so the downstream `delay` can subtract arbitration latency from its programmed delay. The block also tracks spikes lost to overrun.

---
 rtl/spike_pkg.sv | 16 +
 rtl/spike_rr_arbiter_rr_select.sv | 33 +++
 rtl/spike_rr_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/spike_pkg.sv
// Shared defaults, the wait-count saturation helper and the spike bus type
// for the spike round-robin arbiter.
package spike_pkg;

  localparam int unsigned N_IN_DEF   = 4;
  localparam int unsigned W_WAIT_DEF = 4;

  function automatic int unsigned wait_sat(input int unsigned w);
    return (1 << w) - 1;
  endfunction

  localparam int unsigned WAIT_SAT_DEF = wait_sat(W_WAIT_DEF);

  typedef logic [N_IN_DEF-1:0] spike_vec_t;

endpackage

// File: rtl/spike_rr_arbiter_rr_select.sv
// Combinational rotate-priority picker: first set bit of cand at or after ptr,
// wrapping from N-1 back to 0.
module rr_select
  import spike_pkg::*;
#(
  parameter int unsigned N = N_IN_DEF,
  parameter int unsigned W = $clog2(N_IN_DEF)
) (
  input  logic [N-1:0] cand_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  int unsigned k;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      k = (32'(ptr_i) + off) % N;
      if (!any_o && cand_i[k]) begin
        any_o      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = W'(k);
      end
    end
  end

endmodule

// File: rtl/spike_rr_arbiter.sv
// Round-robin spike arbiter with per-input pending/wait tracking and overrun
// detection. Optional lost-spike counter: define SPIKE_ARB_DROP_CNT_EN.
module spike_rr_arbiter
  import spike_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned W_WAIT = W_WAIT_DEF,
  parameter int unsigned W_IDX  = $clog2(N_IN)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_IN-1:0]   i_spike,
  input  logic              i_ready,
  output logic [N_IN-1:0]   o_spike,
  output logic [W_IDX-1:0]  o_idx,
  output logic [W_WAIT-1:0] o_wait,
  output logic              o_busy,
  output logic              o_drop
`ifdef SPIKE_ARB_DROP_CNT_EN
  ,
  output logic [15:0]       o_drop_cnt
`endif
);

  localparam logic [W_WAIT-1:0] WAIT_SAT = W_WAIT'(wait_sat(W_WAIT));

  logic [N_IN-1:0]              pend_q, pend_d;
  logic [N_IN-1:0][W_WAIT-1:0]  wcnt_q, wcnt_d;
  logic [W_IDX-1:0]             ptr_q, ptr_d;
  logic [N_IN-1:0]              cand, sel_gnt, gnt, lost;
  logic [W_IDX-1:0]             sel_idx;
  logic                         sel_any, fire;
  logic [W_WAIT-1:0]            wait_d;

  logic [N_IN-1:0]              spike_q;
  logic [W_IDX-1:0]             idx_q;
  logic [W_WAIT-1:0]            wait_q;
  logic                         busy_q, drop_q;

  assign cand = pend_q | i_spike;

  rr_select #(.N(N_IN), .W(W_IDX)) u_sel (
    .cand_i  (cand),
    .ptr_i   (ptr_q),
    .grant_o (sel_gnt),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  assign fire = sel_any & i_ready;
  assign gnt  = fire ? sel_gnt : '0;

  always_comb begin
    pend_d = pend_q;
    wcnt_d = wcnt_q;
    lost   = '0;
    wait_d = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (gnt[i]) begin
        pend_d[i] = i_spike[i] & pend_q[i];
        wcnt_d[i] = '0;
        // wcnt excludes the edge the event became pending on; the reported wait includes it
        if (pend_q[i])
          wait_d = (wcnt_q[i] == WAIT_SAT) ? WAIT_SAT : wcnt_q[i] + 1'b1;
      end else if (pend_q[i]) begin
        lost[i] = i_spike[i];
        if (wcnt_q[i] != WAIT_SAT)
          wcnt_d[i] = wcnt_q[i] + 1'b1;
      end else if (i_spike[i]) begin
        pend_d[i] = 1'b1;
        wcnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire)
      ptr_d = (sel_idx == W_IDX'(N_IN - 1)) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q  <= '0;
      wcnt_q  <= '0;
      ptr_q   <= '0;
      spike_q <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
      ptr_q   <= ptr_d;
      spike_q <= gnt;
      idx_q   <= fire ? sel_idx : '0;
      wait_q  <= wait_d;
      busy_q  <= |pend_d;
      drop_q  <= |lost;
    end
  end

  assign o_spike = spike_q;
  assign o_idx   = idx_q;
  assign o_wait  = wait_q;
  assign o_busy  = busy_q;
  assign o_drop  = drop_q;

`ifdef SPIKE_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int unsigned i = 0; i < N_IN; i++)
      drop_sum = drop_sum + 17'(lost[i]);
    drop_cnt_d = drop_sum[16] ? '1 : drop_sum[15:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule
